// File: rtl/ecg_conv_feeder.sv
// ecg_conv_feeder: host-side operand feeder for the ECG CNN core.
// Holds a sample window and a small kernel-weight set written by the host,
// pulses core_start once per run, then issues one sample/weight pair per
// cycle while the core reports a CONV state. On core_done (or timeout) the
// core result is captured and held until the host acknowledges it.
//
// Handshake: result_valid rises when a result is captured and stays high,
// with result/result_err stable, until result_ack is seen high at a rising
// clock edge; that edge clears result_valid and returns the block to IDLE.
// run is sampled only in IDLE; run with result_ack in RESULT is ignored.
module ecg_conv_feeder #(
  parameter int N       = 16,
  parameter int DEPTH   = 64,
  parameter int KLEN    = 3,
  parameter int TIMEOUT = 4096,
  parameter int ST_C1   = 1,
  parameter int ST_C2   = 3,
  parameter int ST_C3   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic signed [N-1:0]          wr_data,
  input  logic                         run,
  output logic                         busy,
  output logic                         core_start,
  input  logic [3:0]                   core_state,
  input  logic                         core_done,
  input  logic signed [N-1:0]          core_result,
  output logic signed [N-1:0]          xin,
  output logic signed [N-1:0]          win,
  output logic signed [N-1:0]          result,
  output logic                         result_valid,
  output logic                         result_err,
  input  logic                         result_ack,
  output logic [15:0]                  feed_count,
  output logic [1:0]                   dbg_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int TW  = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam int TMW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_FEED, S_RESULT} state_t;

  state_t state, next_state;

  logic signed [N-1:0] smem [DEPTH];
  logic signed [N-1:0] wmem [KLEN];

  logic [AW-1:0]  rd_ptr;
  logic [TW-1:0]  tap;
  logic [TMW-1:0] timer;
  logic [AW-1:0]  w_mod;
  logic           is_conv;
  logic           timed_out;

  assign w_mod     = wr_addr % AW'(KLEN);
  assign is_conv   = (core_state == 4'(ST_C1)) || (core_state == 4'(ST_C2)) ||
                     (core_state == 4'(ST_C3));
  assign timed_out = (timer == TMW'(TIMEOUT - 1));

  // Host buffer writes, accepted only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      if (wr_sel) wmem[w_mod[TW-1:0]] <= wr_data;
      else        smem[wr_addr]       <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    core_start = 1'b0;
    dbg_state  = state;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) next_state = S_KICK;
      end
      S_KICK: begin
        core_start = 1'b1;
        next_state = S_FEED;
      end
      S_FEED: begin
        if (core_done || timed_out) next_state = S_RESULT;
      end
      S_RESULT: begin
        if (result_ack) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand streaming, pointer/timer bookkeeping and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      tap          <= '0;
      timer        <= '0;
      feed_count   <= '0;
      xin          <= '0;
      win          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            rd_ptr     <= '0;
            tap        <= '0;
            timer      <= '0;
            feed_count <= '0;
          end
        end
        S_FEED: begin
          timer <= timer + 1'b1;
          if (core_done) begin
            // Done takes priority over a CONV state in the same cycle.
            result       <= core_result;
            result_valid <= 1'b1;
            result_err   <= 1'b0;
            xin          <= '0;
            win          <= '0;
          end else if (timed_out) begin
            result       <= '0;
            result_valid <= 1'b1;
            result_err   <= 1'b1;
            xin          <= '0;
            win          <= '0;
          end else if (is_conv) begin
            xin    <= smem[rd_ptr];
            win    <= wmem[tap];
            rd_ptr <= rd_ptr + 1'b1;
            tap    <= (tap == TW'(KLEN - 1)) ? '0 : tap + 1'b1;
            if (feed_count != 16'hFFFF) feed_count <= feed_count + 16'd1;
          end else begin
            xin <= '0;
            win <= '0;
          end
        end
        S_RESULT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            result_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_conv_feeder.sv
// Directed testbench for ecg_conv_feeder: reset, nominal stream, gaps and
// wrap, done/CONV and write collisions, timeout, ack hold and restart.
module tb_ecg_conv_feeder;

  localparam int N       = 16;
  localparam int DEPTH   = 64;
  localparam int KLEN    = 3;
  localparam int TIMEOUT = 256;

  logic                     clk;
  logic                     rst;
  logic                     wr_en;
  logic                     wr_sel;
  logic [5:0]               wr_addr;
  logic signed [N-1:0]      wr_data;
  logic                     run;
  logic                     busy;
  logic                     core_start;
  logic [3:0]               core_state;
  logic                     core_done;
  logic signed [N-1:0]      core_result;
  logic signed [N-1:0]      xin;
  logic signed [N-1:0]      win;
  logic signed [N-1:0]      result;
  logic                     result_valid;
  logic                     result_err;
  logic                     result_ack;
  logic [15:0]              feed_count;
  logic [1:0]               dbg_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  ecg_conv_feeder #(.N(N), .DEPTH(DEPTH), .KLEN(KLEN), .TIMEOUT(TIMEOUT),
                    .ST_C1(1), .ST_C2(3), .ST_C3(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .run(run), .busy(busy), .core_start(core_start),
    .core_state(core_state), .core_done(core_done), .core_result(core_result),
    .xin(xin), .win(win), .result(result), .result_valid(result_valid),
    .result_err(result_err), .result_ack(result_ack), .feed_count(feed_count),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Count start pulses away from the active edge.
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [5:0] addr, input logic signed [N-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Pulse run, pass through KICK, leave the DUT in FEED with core_state idle.
  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("kick_start", core_start, 1);
    core_state = 4'd0;
    tick();
    chk("feed_entry_start_low", core_start, 0);
  endtask

  initial begin
    int cyc;
    int snap;
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    run = 1'b0; core_state = 4'd0; core_done = 1'b0; core_result = '0;
    result_ack = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_xin", xin, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_feed_count", feed_count, 0);
    rst = 1'b1;
    tick();

    // Load samples i*10 and weights 2,2,2.
    for (int i = 0; i < DEPTH; i++) wr(1'b0, 6'(i), 16'(i * 10));
    for (int i = 0; i < KLEN; i++) wr(1'b1, 6'(i), 16'sd2);

    // Nominal stream: core states 1,1,3,4 then done with 123.
    start_run();
    chk("nom_busy", busy, 1);
    core_state = 4'd1; tick(); chk("nom_xin0", xin, 0);  chk("nom_win0", win, 2);
    core_state = 4'd1; tick(); chk("nom_xin1", xin, 10); chk("nom_win1", win, 2);
    core_state = 4'd3; tick(); chk("nom_xin2", xin, 20); chk("nom_win2", win, 2);
    core_state = 4'd4; tick(); chk("nom_xin3", xin, 30); chk("nom_win3", win, 2);
    core_state = 4'd0; core_done = 1'b1; core_result = 16'sd123;
    tick();
    core_done = 1'b0;
    chk("nom_result", result, 123);
    chk("nom_valid", result_valid, 1);
    chk("nom_err", result_err, 0);
    chk("nom_fc", feed_count, 4);
    chk("nom_xin_zero", xin, 0);
    chk("nom_start_pulses", start_cnt, 1);

    // Ack hold: outputs stable while ack is low.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", result_valid, 1);
      chk("hold_result", result, 123);
    end
    // Ack with run: back to IDLE without KICK, then run re-sampled.
    result_ack = 1'b1; run = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("ack_busy", busy, 0);
    chk("ack_valid", result_valid, 0);
    chk("ack_start", core_start, 0);
    chk("ack_fc_hold", feed_count, 4);
    chk("ack_result_hold", result, 123);
    tick();
    run = 1'b0;
    chk("restart_kick", core_start, 1);

    // Collisions: writes during FEED ignored; done in a CONV1 cycle wins.
    core_state = 4'd0;
    tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd1; wr_data = 16'sd777;
    tick();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd1; wr_data = 16'sd99;
    tick();
    wr_en = 1'b0;
    core_state = 4'd1; tick();
    chk("col_xin0", xin, 0);
    chk("col_fc1", feed_count, 1);
    core_state = 4'd1; core_done = 1'b1; core_result = 16'sd55;
    tick();
    core_done = 1'b0; core_state = 4'd0;
    chk("col_fc_unchanged", feed_count, 1);
    chk("col_xin_zero", xin, 0);
    chk("col_result", result, 55);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    chk("col_idle", busy, 0);

    // Gaps and wrap: weights 1,2,3; CONV1 alternating with state 2.
    for (int i = 0; i < KLEN; i++) wr(1'b1, 6'(i), 16'(i + 1));
    start_run();
    for (int k = 0; k < 70; k++) begin
      core_state = 4'd1; tick();
      chk("wrap_xin", xin, 32'((k % 64) * 10));
      chk("wrap_win", win, 32'((k % 3) + 1));
      core_state = 4'd2; tick();
      chk("gap_xin", xin, 0);
      chk("gap_win", win, 0);
    end
    chk("wrap_fc", feed_count, 70);
    core_state = 4'd0; core_done = 1'b1; core_result = 16'sd77;
    tick();
    core_done = 1'b0;
    chk("wrap_result", result, 77);
    result_ack = 1'b1; tick(); result_ack = 1'b0;

    // Timeout: core never finishes.
    start_run();
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("to_cycles", cyc, TIMEOUT);
    chk("to_valid", result_valid, 1);
    chk("to_err", result_err, 1);
    chk("to_result", result, 0);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    chk("to_err_cleared", result_err, 0);
    chk("to_idle", busy, 0);

    // Reset mid-FEED: outputs drop asynchronously, no start after release.
    start_run();
    core_state = 4'd1; tick(); tick(); tick();
    chk("pre_rst_xin", xin, 20);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_xin", xin, 0);
    chk("mid_rst_win", win, 0);
    chk("mid_rst_fc", feed_count, 0);
    chk("mid_rst_valid", result_valid, 0);
    core_state = 4'd0;
    tick();
    rst = 1'b1;
    snap = start_cnt;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_no_start", start_cnt, snap);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
